// File: rtl/digit_overlay_ctrl_pkg.sv
// Shared types and constants for the digit overlay controller.
package digit_overlay_ctrl_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } upd_state_t;

    localparam int LATENCY     = 4;
    localparam int GLYPH_W     = 8;
    localparam int GLYPH_H     = 16;
    localparam int ROM_LATENCY = 2;

    localparam logic [3:0] BCD_BLANK_MIN = 4'd10;

    // Per-pixel information that has to wait for the ROM data to come back.
    typedef struct packed {
        logic       valid;
        logic       active;
        logic       blank;
        logic [2:0] bit_sel;
    } side_t;

endpackage

// File: rtl/digit_overlay_ctrl_if.sv
// Raster, value-update, character ROM and overlay signals of the digit overlay.
interface digit_overlay_ctrl_if #(
    parameter int DIGITS  = 4,
    parameter int COORD_W = 12
);
    logic                  pix_valid;
    logic [COORD_W-1:0]    pix_x;
    logic [COORD_W-1:0]    pix_y;
    logic                  frame_start;
    logic [4*DIGITS-1:0]   value_bcd;
    logic                  value_load;
    logic [7:0]            rom_address;
    logic [7:0]            rom_q;
    logic                  ovl_valid;
    logic                  ovl_active;
    logic                  ovl_pixel;

    modport master (
        output pix_valid, pix_x, pix_y, frame_start, value_bcd, value_load, rom_q,
        input  rom_address, ovl_valid, ovl_active, ovl_pixel
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, frame_start, value_bcd, value_load, rom_q,
        output rom_address, ovl_valid, ovl_active, ovl_pixel
    );
endinterface

// File: rtl/digit_overlay_ctrl_blank_mask.sv
// Per-digit blank mask: invalid display, non-decimal nibbles and leading zeros.
module digit_blank_mask
    import digit_overlay_ctrl_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int BLANK_LEADING = 1
) (
    input  logic [4*DIGITS-1:0] bcd,
    input  logic                valid,
    output logic [DIGITS-1:0]   blank
);

    logic zero_run;

    // Walk from the most significant digit down; digit 0 always stays visible.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (bcd[4*i +: 4] == 4'h0);
            blank[i] = !valid
                    || (bcd[4*i +: 4] >= BCD_BLANK_MIN)
                    || ((BLANK_LEADING != 0) && (i != 0) && zero_run);
        end
    end

endmodule

// File: rtl/digit_overlay_ctrl.sv
// Draws a DIGITS-wide decimal number from an external glyph ROM over the raster,
// with the displayed value double-buffered to frame boundaries.
module digit_overlay_ctrl
    import digit_overlay_ctrl_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int POS_X         = 64,
    parameter int POS_Y         = 32,
    parameter int SCALE_LOG2    = 0,
    parameter int BLANK_LEADING = 1,
    parameter int COORD_W       = 12
) (
    input  logic                 clock,
    input  logic                 reset_n,
    digit_overlay_ctrl_if.slave  bus
);

    localparam logic [COORD_W:0]   POS_X_EXT  = (COORD_W+1)'(POS_X);
    localparam logic [COORD_W:0]   POS_Y_EXT  = (COORD_W+1)'(POS_Y);
    localparam logic [COORD_W-1:0] BOX_COLS   = COORD_W'(GLYPH_W * DIGITS);
    localparam logic [COORD_W-1:0] BOX_ROWS   = COORD_W'(GLYPH_H);
    localparam logic [2:0]         LAST_DIGIT = 3'(DIGITS - 1);

    upd_state_t            state_q, state_d;
    logic                  commit;
    logic [4*DIGITS-1:0]   pending_q, display_q;
    logic                  display_valid_q;
    logic [DIGITS-1:0]     blank_vec;

    logic                  s0_valid;
    logic [COORD_W-1:0]    s0_x, s0_y;
    logic [COORD_W:0]      dx, dy;
    logic [COORD_W-1:0]    col, row;
    logic                  in_box;
    logic [2:0]            digit_idx;
    logic [3:0]            code;
    logic                  blank_sel;
    side_t                 side_d;
    side_t                 side_q [1:LATENCY-1];

    // Update FSM: a new value waits in pending until the next frame_start.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            pending_q       <= '0;
            display_q       <= '0;
            display_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (commit) begin
                display_q       <= pending_q;
                display_valid_q <= 1'b1;
            end
            if (bus.value_load) begin
                pending_q <= bus.value_bcd;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.value_load) state_d = ST_PENDING;
            end
            ST_PENDING: begin
                commit = bus.frame_start;
                if (bus.value_load)       state_d = ST_PENDING;
                else if (bus.frame_start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    digit_blank_mask #(
        .DIGITS        (DIGITS),
        .BLANK_LEADING (BLANK_LEADING)
    ) u_blank_mask (
        .bcd   (display_q),
        .valid (display_valid_q),
        .blank (blank_vec)
    );

    // Box geometry: the extra top bit of dx/dy is the borrow for pixels left of or above the box.
    always_comb begin
        dx        = {1'b0, s0_x} - POS_X_EXT;
        dy        = {1'b0, s0_y} - POS_Y_EXT;
        col       = dx[COORD_W-1:0] >> SCALE_LOG2;
        row       = dy[COORD_W-1:0] >> SCALE_LOG2;
        in_box    = !dx[COORD_W] && !dy[COORD_W] && (col < BOX_COLS) && (row < BOX_ROWS);
        digit_idx = LAST_DIGIT - col[5:3];
        code      = 4'h0;
        blank_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx == 3'(i)) begin
                code      = display_q[4*i +: 4];
                blank_sel = blank_vec[i];
            end
        end
        side_d.valid   = s0_valid;
        side_d.active  = in_box;
        side_d.blank   = blank_sel;
        side_d.bit_sel = 3'd7 - col[2:0];
    end

    // Pixel pipeline: sample, address, two ROM cycles, then pick the glyph bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid        <= 1'b0;
            s0_x            <= '0;
            s0_y            <= '0;
            bus.rom_address <= 8'h00;
            for (int i = 1; i < LATENCY; i++) side_q[i] <= '0;
            bus.ovl_valid   <= 1'b0;
            bus.ovl_active  <= 1'b0;
            bus.ovl_pixel   <= 1'b0;
        end else begin
            s0_valid <= bus.pix_valid;
            s0_x     <= bus.pix_x;
            s0_y     <= bus.pix_y;
            if (!in_box)                    bus.rom_address <= 8'h00;
            else if (code < BCD_BLANK_MIN)  bus.rom_address <= {code, row[3:0]};
            else                            bus.rom_address <= {4'h0, row[3:0]};
            side_q[1] <= side_d;
            for (int i = 2; i < LATENCY; i++) side_q[i] <= side_q[i-1];
            bus.ovl_valid  <= side_q[LATENCY-1].valid;
            bus.ovl_active <= side_q[LATENCY-1].active;
            bus.ovl_pixel  <= bus.rom_q[side_q[LATENCY-1].bit_sel]
                              & side_q[LATENCY-1].active & ~side_q[LATENCY-1].blank;
        end
    end

endmodule

// File: tb/tb_digit_overlay_ctrl.sv
// Bench for digit_overlay_ctrl: unscaled and 2x-scaled instances sharing one raster stream.
module tb_digit_overlay_ctrl;

    localparam int DIGITS = 4;
    localparam int POS_X  = 64;
    localparam int POS_Y  = 32;

    typedef struct packed {
        logic [7:0] addr;
        logic       valid;
        logic       active;
        logic       pixel;
    } exp_t;

    typedef struct {
        string       name;
        logic [15:0] value;
        int          x;
        int          y;
        logic [7:0]  addr;
        logic        active;
        logic        pixel;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    digit_overlay_ctrl_if #(.DIGITS(DIGITS), .COORD_W(12)) bus0 ();
    digit_overlay_ctrl_if #(.DIGITS(DIGITS), .COORD_W(12)) bus1 ();

    digit_overlay_ctrl #(
        .DIGITS(DIGITS), .POS_X(POS_X), .POS_Y(POS_Y),
        .SCALE_LOG2(0), .BLANK_LEADING(1), .COORD_W(12)
    ) dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    digit_overlay_ctrl #(
        .DIGITS(DIGITS), .POS_X(POS_X), .POS_Y(POS_Y),
        .SCALE_LOG2(1), .BLANK_LEADING(1), .COORD_W(12)
    ) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    assign bus1.pix_valid   = bus0.pix_valid;
    assign bus1.pix_x       = bus0.pix_x;
    assign bus1.pix_y       = bus0.pix_y;
    assign bus1.frame_start = bus0.frame_start;
    assign bus1.value_bcd   = bus0.value_bcd;
    assign bus1.value_load  = bus0.value_load;

    always #5 clock = ~clock;

    // Glyph ROM content chosen so expected bits can be worked out by hand.
    function automatic logic [7:0] glyph(input logic [7:0] a);
        return a ^ 8'h5A;
    endfunction

    logic [7:0] rom0_s1, rom1_s1;
    always @(posedge clock) begin
        rom0_s1    <= glyph(bus0.rom_address);
        bus0.rom_q <= rom0_s1;
        rom1_s1    <= glyph(bus1.rom_address);
        bus1.rom_q <= rom1_s1;
    end

    // Reference: what a pixel at (x, y) should show for a given displayed number.
    function automatic exp_t model_pix(input int scale, input logic v, input int x, input int y,
                                       input logic [15:0] val, input logic shown);
        exp_t        e;
        int          c, r, d, nib;
        logic [15:0] hi;
        logic [7:0]  a, g;
        e       = '0;
        e.valid = v;
        if (x >= POS_X && y >= POS_Y) begin
            c = (x - POS_X) >> scale;
            r = (y - POS_Y) >> scale;
            if (c < 8 * DIGITS && r < 16) begin
                d        = DIGITS - 1 - c / 8;
                hi       = val >> (4 * d);
                nib      = int'(hi[3:0]);
                a        = 8'((nib > 9 ? 0 : nib) * 16 + r);
                g        = glyph(a);
                e.active = 1'b1;
                e.addr   = a;
                e.pixel  = shown && nib <= 9 && (d == 0 || hi != 0) && g[7 - c % 8];
            end
        end
        return e;
    endfunction

    logic [15:0] m_pend = '0, m_disp = '0;
    logic        m_pend_ok = 1'b0, m_disp_ok = 1'b0;
    exp_t        hist0 [5] = '{default: '0};
    exp_t        hist1 [5] = '{default: '0};

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_pend = '0; m_disp = '0; m_pend_ok = 1'b0; m_disp_ok = 1'b0;
            for (int i = 0; i < 5; i++) begin
                hist0[i] = '0;
                hist1[i] = '0;
            end
        end else begin
            if (bus0.frame_start && m_pend_ok) begin
                m_disp    = m_pend;
                m_disp_ok = 1'b1;
                m_pend_ok = 1'b0;
            end
            if (bus0.value_load) begin
                m_pend    = bus0.value_bcd;
                m_pend_ok = 1'b1;
            end
            for (int i = 4; i > 0; i--) begin
                hist0[i] = hist0[i-1];
                hist1[i] = hist1[i-1];
            end
            hist0[0] = model_pix(0, bus0.pix_valid, int'(bus0.pix_x), int'(bus0.pix_y), m_disp, m_disp_ok);
            hist1[0] = model_pix(1, bus0.pix_valid, int'(bus0.pix_x), int'(bus0.pix_y), m_disp, m_disp_ok);
        end
    end

    task automatic compare(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h t=%0t", name, actual, expected, $time);
        end
    endtask

    // Continuous comparison against the reference pipeline for both instances.
    always @(negedge clock) begin
        compare("m0_addr",   int'(bus0.rom_address), int'(hist0[1].addr));
        compare("m0_valid",  int'(bus0.ovl_valid),   int'(hist0[4].valid));
        compare("m0_active", int'(bus0.ovl_active),  int'(hist0[4].active));
        compare("m0_pixel",  int'(bus0.ovl_pixel),   int'(hist0[4].pixel));
        compare("m1_addr",   int'(bus1.rom_address), int'(hist1[1].addr));
        compare("m1_valid",  int'(bus1.ovl_valid),   int'(hist1[4].valid));
        compare("m1_active", int'(bus1.ovl_active),  int'(hist1[4].active));
        compare("m1_pixel",  int'(bus1.ovl_pixel),   int'(hist1[4].pixel));
    end

    task automatic drive_cycle(input logic v, input int x, input int y,
                               input logic fs, input logic ld, input logic [15:0] val);
        @(negedge clock);
        bus0.pix_valid   = v;
        bus0.pix_x       = 12'(x);
        bus0.pix_y       = 12'(y);
        bus0.frame_start = fs;
        bus0.value_load  = ld;
        bus0.value_bcd   = val;
    endtask

    task automatic load_value(input logic [15:0] val);
        drive_cycle(1'b0, 0, 0, 1'b0, 1'b1, val);
        drive_cycle(1'b0, 0, 0, 1'b1, 1'b0, val);
    endtask

    // One pixel at edge k; address checked after k+1, overlay after k+4.
    task automatic check_output(input string name, input bit sel, input int x, input int y,
                                input logic [7:0] ea, input logic eact, input logic epix);
        drive_cycle(1'b1, x, y, 1'b0, 1'b0, 16'h0);
        drive_cycle(1'b0, 0, 0, 1'b0, 1'b0, 16'h0);
        @(posedge clock);
        #1;
        compare({name, "_addr"}, int'(sel ? bus1.rom_address : bus0.rom_address), int'(ea));
        repeat (3) @(posedge clock);
        #1;
        compare({name, "_act"}, int'(sel ? bus1.ovl_active : bus0.ovl_active), int'(eact));
        compare({name, "_pix"}, int'(sel ? bus1.ovl_pixel : bus0.ovl_pixel), int'(epix));
    endtask

    task automatic apply_stimulus(input vec_t v);
        load_value(v.value);
        check_output(v.name, 1'b0, v.x, v.y, v.addr, v.active, v.pixel);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            case ($urandom_range(3, 0))
                0:       r[4*i +: 4] = 4'h0;
                1:       r[4*i +: 4] = 4'($urandom_range(9, 1));
                default: r[4*i +: 4] = 4'($urandom_range(15, 0));
            endcase
        end
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{"v0420_s0",  16'h0420, POS_X,      POS_Y + 3,  8'h03, 1'b1, 1'b0};
        vecs[1]  = '{"v0420_s1",  16'h0420, POS_X + 11, POS_Y + 3,  8'h43, 1'b1, 1'b1};
        vecs[2]  = '{"v1234_s1",  16'h1234, POS_X + 10, POS_Y + 5,  8'h25, 1'b1, 1'b1};
        vecs[3]  = '{"left_out",  16'h1234, POS_X - 1,  POS_Y + 5,  8'h00, 1'b0, 1'b0};
        vecs[4]  = '{"right_out", 16'h1234, POS_X + 32, POS_Y + 5,  8'h00, 1'b0, 1'b0};
        vecs[5]  = '{"corner_br", 16'h1234, POS_X + 31, POS_Y + 15, 8'h4F, 1'b1, 1'b1};
        vecs[6]  = '{"below_out", 16'h1234, POS_X + 6,  POS_Y + 16, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{"above_out", 16'h1234, POS_X + 6,  POS_Y - 1,  8'h00, 1'b0, 1'b0};
        vecs[8]  = '{"zero_s3",   16'h0000, POS_X + 25, POS_Y + 1,  8'h01, 1'b1, 1'b1};
        vecs[9]  = '{"zero_s2",   16'h0000, POS_X + 17, POS_Y + 1,  8'h01, 1'b1, 1'b0};
        vecs[10] = '{"hexA_s2",   16'h00A5, POS_X + 17, POS_Y + 1,  8'h01, 1'b1, 1'b0};
        vecs[11] = '{"hex5_s3",   16'h00A5, POS_X + 28, POS_Y + 1,  8'h51, 1'b1, 1'b1};

        bus0.pix_valid = 1'b0; bus0.pix_x = '0; bus0.pix_y = '0;
        bus0.frame_start = 1'b0; bus0.value_load = 1'b0; bus0.value_bcd = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        $display("[TB] reset released");

        compare("rst_addr",  int'(bus0.rom_address), 0);
        compare("rst_valid", int'(bus0.ovl_valid),   0);
        compare("rst_pixel", int'(bus0.ovl_pixel),   0);
        check_output("preload", 1'b0, POS_X + 26, POS_Y + 1, 8'h01, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) apply_stimulus(vecs[i]);

        // Double buffering: mid-frame load, then load and frame_start together.
        load_value(16'h0420);
        check_output("db_base", 1'b0, POS_X, POS_Y, 8'h00, 1'b1, 1'b0);
        drive_cycle(1'b0, 0, 0, 1'b0, 1'b1, 16'h1111);
        check_output("db_hold", 1'b0, POS_X, POS_Y, 8'h00, 1'b1, 1'b0);
        drive_cycle(1'b0, 0, 0, 1'b1, 1'b1, 16'h2222);
        check_output("db_old", 1'b0, POS_X, POS_Y, 8'h10, 1'b1, 1'b0);
        drive_cycle(1'b0, 0, 0, 1'b1, 1'b0, 16'h0);
        check_output("db_new", 1'b0, POS_X, POS_Y, 8'h20, 1'b1, 1'b0);
        drive_cycle(1'b0, 0, 0, 1'b1, 1'b0, 16'h0);
        check_output("db_idle_fs", 1'b0, POS_X, POS_Y, 8'h20, 1'b1, 1'b0);

        // 2x magnification on the second instance.
        load_value(16'h1234);
        check_output("x2_p00",   1'b1, POS_X,      POS_Y,     8'h10, 1'b1, 1'b0);
        check_output("x2_p11",   1'b1, POS_X + 1,  POS_Y + 1, 8'h10, 1'b1, 1'b0);
        check_output("x2_col1",  1'b1, POS_X + 2,  POS_Y,     8'h10, 1'b1, 1'b1);
        check_output("x2_edge",  1'b1, POS_X + 63, POS_Y,     8'h40, 1'b1, 1'b0);
        check_output("x2_out",   1'b1, POS_X + 64, POS_Y,     8'h00, 1'b0, 1'b0);

        // Reset in the middle of a line of visible pixels.
        load_value(16'h8888);
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, POS_X + 3 * i, POS_Y + 4, 1'b0, 1'b0, 16'h0);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        compare("async_valid",  int'(bus0.ovl_valid),   0);
        compare("async_active", int'(bus0.ovl_active),  0);
        compare("async_addr",   int'(bus0.rom_address), 0);
        compare("async_valid1", int'(bus1.ovl_valid),   0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int s = 0; s < DIGITS; s++) begin
            check_output("post_rst", 1'b0, POS_X + 8 * s + 3, POS_Y + 2, 8'h02, 1'b1, 1'b0);
        end
        drive_cycle(1'b0, 0, 0, 1'b1, 1'b0, 16'h0);
        check_output("post_rst_fs", 1'b0, POS_X + 27, POS_Y + 2, 8'h02, 1'b1, 1'b0);

        // Random raster around both boxes with random loads and frame starts.
        for (int n = 0; n < 2000; n++) begin
            drive_cycle(1'($urandom_range(1, 0)),
                        int'($urandom_range(135, 0)) + POS_X - 4,
                        int'($urandom_range(39, 0)) + POS_Y - 3,
                        ($urandom_range(15, 0) == 0),
                        ($urandom_range(7, 0) == 0),
                        rand_bcd());
        end
        drive_cycle(1'b0, 0, 0, 1'b0, 1'b0, 16'h0);
        repeat (6) @(posedge clock);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
